// File: rtl/mult_div_unit_if.sv
// ============================================================================
// mult_div_unit_if : operand/op/result bundle between the pipeline and the MDU
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_div_unit_if;
  logic [31:0] Src1;
  logic [31:0] Src2;
  logic [3:0]  MDOP;
  logic        Start;
  logic        Cancel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Src1, Src2, MDOP, Start, Cancel,
    input  Busy, HI, LO
  );

  modport slave (
    input  Src1, Src2, MDOP, Start, Cancel,
    output Busy, HI, LO
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit : MIPS-style HI/LO multiply/divide unit with fixed-latency busy
// Optional macro MDU_MADD_EN enables madd/maddu (MDOP 7/8) accumulate ops.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mult_div_unit_if.slave  mdu
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t        state;
  logic          busy;
  logic [CW-1:0] count;
  logic [31:0]   src1_lat;
  logic [31:0]   src2_lat;
  logic [3:0]    op_lat;
  logic [31:0]   hi;
  logic [31:0]   lo;

  logic          op_ok;
  logic          accept;
  logic [63:0]   ext_a;
  logic [63:0]   ext_b;
  logic [63:0]   product;
  logic [63:0]   mul_result;
  logic          div_signed;
  logic          div_zero;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [31:0]   q_mag;
  logic [31:0]   r_mag;
  logic [31:0]   quotient;
  logic [31:0]   remainder;

  assign mdu.Busy = busy;
  assign mdu.HI   = hi;
  assign mdu.LO   = lo;

  always_comb begin
    op_ok = 1'b0;
    case (mdu.MDOP)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: op_ok = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: op_ok = 1'b1;
`endif
      default: op_ok = 1'b0;
    endcase
  end

  assign accept = mdu.Start && !mdu.Cancel && !busy && op_ok;

  // A 64x64 product of sign-/zero-extended operands, truncated to 64 bits,
  // yields the correct signed or unsigned 32x32 result.
  always_comb begin
    if (op_lat == OP_MULT || op_lat == OP_MADD) begin
      ext_a = {{32{src1_lat[31]}}, src1_lat};
      ext_b = {{32{src2_lat[31]}}, src2_lat};
    end else begin
      ext_a = {32'd0, src1_lat};
      ext_b = {32'd0, src2_lat};
    end
    product    = ext_a * ext_b;
    mul_result = product;
`ifdef MDU_MADD_EN
    if (op_lat == OP_MADD || op_lat == OP_MADDU)
      mul_result = {hi, lo} + product;
`endif
  end

  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
  always_comb begin
    div_signed = (op_lat == OP_DIV);
    div_zero   = (src2_lat == 32'd0);
    mag_a      = (div_signed && src1_lat[31]) ? (32'd0 - src1_lat) : src1_lat;
    mag_b      = (div_signed && src2_lat[31]) ? (32'd0 - src2_lat) : src2_lat;
    q_mag      = mag_a / (div_zero ? 32'd1 : mag_b);
    r_mag      = mag_a % (div_zero ? 32'd1 : mag_b);
    quotient   = (div_signed && (src1_lat[31] ^ src2_lat[31])) ? (32'd0 - q_mag) : q_mag;
    remainder  = (div_signed && src1_lat[31]) ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      count    <= '0;
      src1_lat <= 32'd0;
      src2_lat <= 32'd0;
      op_lat   <= 4'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (mdu.MDOP)
              OP_MTHI: hi <= mdu.Src1;
              OP_MTLO: lo <= mdu.Src1;
              OP_DIV, OP_DIVU: begin
                src1_lat <= mdu.Src1;
                src2_lat <= mdu.Src2;
                op_lat   <= mdu.MDOP;
                state    <= S_DIV;
                busy     <= 1'b1;
                count    <= {{(CW-1){1'b0}}, 1'b1};
              end
              default: begin
                src1_lat <= mdu.Src1;
                src2_lat <= mdu.Src2;
                op_lat   <= mdu.MDOP;
                state    <= S_MUL;
                busy     <= 1'b1;
                count    <= {{(CW-1){1'b0}}, 1'b1};
              end
            endcase
          end
        end
        S_MUL: begin
          if (count >= MULT_N) begin
            {hi, lo} <= mul_result;
            state    <= S_IDLE;
            busy     <= 1'b0;
            count    <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DIV: begin
          if (count >= DIV_N) begin
            if (!div_zero) begin
              hi <= remainder;
              lo <= quotient;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// tb_mult_div_unit : vector table + scoreboard bench for mult_div_unit
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mult_div_unit_if bus ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  exp_t sb [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles including the accepting one; caller has just sampled Busy=1.
  task automatic wait_done(input string name, output int n);
    n = 1;
    for (int k = 0; k < 100 && bus.Busy; k++) begin
      tick();
      if (bus.Busy) n++;
    end
    if (bus.Busy) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: Busy still 1 after 100 cycles", name);
    end
  endtask

  task automatic idle_inputs();
    bus.Start  = 1'b0;
    bus.Cancel = 1'b0;
    bus.MDOP   = 4'd0;
    bus.Src1   = 32'd0;
    bus.Src2   = 32'd0;
  endtask

  function automatic vec_t mk(string n, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] hi, logic [31:0] lo, int cyc);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.cyc = cyc;
    return v;
  endfunction

  initial begin
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    exp_t        e;
    int          n;

    vecs[0]  = mk("mult_m2x3",   4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    vecs[1]  = mk("multu_max",   4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    vecs[2]  = mk("div_m7d2",    4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    vecs[3]  = mk("mthi_11",     4'd5, 32'h11,       32'd0,        32'h11,       32'hFFFFFFFD, 0);
    vecs[4]  = mk("mtlo_22",     4'd6, 32'h22,       32'd0,        32'h11,       32'h22,       0);
    vecs[5]  = mk("divu_by0",    4'd4, 32'd5,        32'd0,        32'h11,       32'h22,       10);
    vecs[6]  = mk("div_ovf",     4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10);
    vecs[7]  = mk("divu_100d7",  4'd4, 32'd100,      32'd7,        32'd2,        32'd14,       10);
    vecs[8]  = mk("div_7dm2",    4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10);
    vecs[9]  = mk("mult_maxpos", 4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5);
    vecs[10] = mk("mult_minneg", 4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        5);
    vecs[11] = mk("nop_op0",     4'd0, 32'h1234,     32'h5678,     32'h40000000, 32'h0,        0);
    vecs[12] = mk("nop_op12",    4'd12, 32'h1234,    32'h5678,     32'h40000000, 32'h0,        0);
    vecs[13] = mk("mtlo_ffff",   4'd6, 32'hFFFFFFFF, 32'd0,        32'h40000000, 32'hFFFFFFFF, 0);
    vecs[14] = mk("mthi_0",      4'd5, 32'h0,        32'd0,        32'h0,        32'hFFFFFFFF, 0);
`ifdef MDU_MADD_EN
    vecs[15] = mk("madd_1x1",    4'd7, 32'd1,        32'd1,        32'd1,        32'd0,        5);
    vecs[16] = mk("maddu_big",   4'd8, 32'hFFFFFFFF, 32'd2,        32'd2,        32'hFFFFFFFE, 5);
`else
    vecs[15] = mk("madd_off",    4'd7, 32'd1,        32'd1,        32'd0,        32'hFFFFFFFF, 0);
    vecs[16] = mk("maddu_off",   4'd8, 32'hFFFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFF, 0);
`endif

    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_hilo", {bus.HI, bus.LO}, 64'd0);
    check("reset_busy", {63'd0, bus.Busy}, 64'd0);

    prev_hi = 32'd0;
    prev_lo = 32'd0;
    for (int i = 0; i < NV; i++) begin
      bus.Start = 1'b1;
      bus.MDOP  = vecs[i].op;
      bus.Src1  = vecs[i].a;
      bus.Src2  = vecs[i].b;
      sb.push_back('{hi: vecs[i].hi, lo: vecs[i].lo});
      tick();
      idle_inputs();
      if (vecs[i].cyc > 0) begin
        check({vecs[i].name, "_busy_on"}, {63'd0, bus.Busy}, 64'd1);
        check({vecs[i].name, "_hold"}, {bus.HI, bus.LO}, {prev_hi, prev_lo});
        wait_done(vecs[i].name, n);
        check({vecs[i].name, "_cycles"}, 64'(n), 64'(vecs[i].cyc));
      end else begin
        check({vecs[i].name, "_nobusy"}, {63'd0, bus.Busy}, 64'd0);
      end
      e = sb.pop_front();
      check({vecs[i].name, "_hilo"}, {bus.HI, bus.LO}, {e.hi, e.lo});
      prev_hi = e.hi;
      prev_lo = e.lo;
    end

    // Start held through Busy with a Cancel pulse mid-op; second op waits one edge past completion.
    bus.Start = 1'b1; bus.MDOP = 4'd1; bus.Src1 = 32'd2; bus.Src2 = 32'd3;
    tick();
    bus.Src1 = 32'd4; bus.Src2 = 32'd5;
    tick();
    bus.Cancel = 1'b1;
    tick();
    bus.Cancel = 1'b0;
    check("held_busy_mid", {63'd0, bus.Busy}, 64'd1);
    n = 3;
    for (int k = 0; k < 100 && bus.Busy; k++) begin
      tick();
      if (bus.Busy) n++;
    end
    check("held_first_cycles", 64'(n), 64'd5);
    check("held_first_hilo", {bus.HI, bus.LO}, 64'd6);
    tick();
    bus.Start = 1'b0;
    check("held_second_accept", {63'd0, bus.Busy}, 64'd1);
    wait_done("held_second", n);
    check("held_second_cycles", 64'(n), 64'd5);
    check("held_second_hilo", {bus.HI, bus.LO}, 64'd20);

    bus.Start = 1'b1; bus.Cancel = 1'b1; bus.MDOP = 4'd6; bus.Src1 = 32'hDEAD;
    tick();
    idle_inputs();
    check("cancel_idle_busy", {63'd0, bus.Busy}, 64'd0);
    repeat (6) tick();
    check("cancel_idle_hilo", {bus.HI, bus.LO}, 64'd20);

    // Reset in the middle of a divide must discard it.
    bus.Start = 1'b1; bus.MDOP = 4'd4; bus.Src1 = 32'd100; bus.Src2 = 32'd7;
    tick();
    idle_inputs();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_hilo", {bus.HI, bus.LO}, 64'd0);
    check("rst_mid_busy", {63'd0, bus.Busy}, 64'd0);
    repeat (10) tick();
    check("rst_mid_nowrite", {bus.HI, bus.LO}, 64'd0);
    bus.Start = 1'b1; bus.MDOP = 4'd5; bus.Src1 = 32'hABCD;
    tick();
    idle_inputs();
    check("mthi_abcd_hilo", {bus.HI, bus.LO}, {32'hABCD, 32'd0});
    check("mthi_abcd_busy", {63'd0, bus.Busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
